// File: rtl/uart_pkg.sv
// uart_pkg: shared register offsets and STATUS/CTRL bit positions for the UART MMIO controller.
package uart_pkg;
    localparam logic [3:0] UART_STATUS = 4'h0;
    localparam logic [3:0] UART_RX     = 4'h4;
    localparam logic [3:0] UART_TX     = 4'h8;
    localparam logic [3:0] UART_CTRL   = 4'hC;

    localparam int ST_TX_READY = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_TX_EMPTY = 3;
    localparam int ST_TX_DROP  = 4;

    localparam int CTRL_CLR       = 0;
    localparam int CTRL_TX_IRQ_EN = 1;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide synchronous FIFO feeding the UART transmit handshake.
//   push/push_data : enqueue, ignored while full
//   pop            : dequeue, ignored while empty
//   head           : byte at the read pointer
//   full/empty     : occupancy flags; count : occupancy
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = count == CNT_W'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped bridge between the data bus and uart_core.
//   bus_*                      : register access, one-cycle registered read latency
//   uart_data_in*              : TX FIFO head towards uart_core
//   uart_data_out*             : received bytes from uart_core, always accepted
//   irq                        : registered level of rx_valid | (tx_empty & tx_irq_en)
module uart_mmio_ctrl #(
    parameter int TX_FIFO_DEPTH = 8,
    parameter int CNT_W = $clog2(TX_FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  bus_addr,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic [7:0]  uart_data_in,
    output logic        uart_data_in_valid,
    input  logic        uart_data_in_ready,
    input  logic [7:0]  uart_data_out,
    input  logic        uart_data_out_valid,
    output logic        uart_data_out_ready,
    output logic        irq
);
    import uart_pkg::*;

    logic [3:0]       reg_addr;
    logic             wr_tx, wr_ctrl, rd, rd_rx, clr, ovr_set, drop_set;
    logic             tx_full, tx_empty;
    logic [CNT_W-1:0] tx_count;
    logic             rx_valid, overrun, tx_drop, tx_irq_en;
    logic [7:0]       rx_data;
    logic [31:0]      status, rd_val;
    logic             unused_bits;

    assign reg_addr = {bus_addr[3:2], 2'b00};
    assign wr_tx    = bus_we && reg_addr == UART_TX;
    assign wr_ctrl  = bus_we && reg_addr == UART_CTRL;
    assign rd       = bus_re && !bus_we;
    assign rd_rx    = rd && reg_addr == UART_RX;
    assign clr      = wr_ctrl && bus_wdata[CTRL_CLR];
    // A byte arriving while the previous one is unread is an overrun, unless
    // software drains the old byte in this very cycle.
    assign ovr_set  = uart_data_out_valid && rx_valid && !rd_rx;
    assign drop_set = wr_tx && tx_full;

    assign uart_data_in_valid  = !tx_empty;
    assign uart_data_out_ready = 1'b1;
    assign unused_bits         = ^{bus_addr[1:0], bus_wdata[31:8], tx_count};

    uart_tx_fifo #(.DEPTH(TX_FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_tx),
        .push_data (bus_wdata[7:0]),
        .pop       (uart_data_in_ready),
        .head      (uart_data_in),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    always_comb begin
        status              = '0;
        status[ST_TX_READY] = !tx_full;
        status[ST_RX_VALID] = rx_valid;
        status[ST_OVERRUN]  = overrun;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_DROP]  = tx_drop;
        rd_val = reg_addr == UART_STATUS ? status :
                 reg_addr == UART_RX     ? {24'b0, rx_data} :
                 reg_addr == UART_CTRL   ? 32'(tx_irq_en) << CTRL_TX_IRQ_EN : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_rdata <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            overrun   <= 1'b0;
            tx_drop   <= 1'b0;
            tx_irq_en <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (bus_re) bus_rdata <= bus_we ? '0 : rd_val;
            if (uart_data_out_valid) begin
                rx_data  <= uart_data_out;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            overrun <= ovr_set | (overrun & ~clr);
            tx_drop <= drop_set | (tx_drop & ~clr);
            if (wr_ctrl) tx_irq_en <= bus_wdata[CTRL_TX_IRQ_EN];
            irq <= rx_valid | (tx_empty & tx_irq_en);
        end
    end
endmodule
